// File: rtl/dm_arb_pkg.sv
// dm_arbiter shared types: op codes, FSM states
// and the request legality check.
package dm_arb_pkg;

  localparam logic [2:0] OP_LW = 3'd0;
  localparam logic [2:0] OP_SW = 3'd1;
  localparam logic [2:0] OP_SH = 3'd2;
  localparam logic [2:0] OP_SB = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } st_e;

  function automatic logic dm_req_err(
    input logic [31:0] addr,
    input logic [2:0]  op,
    input int unsigned mem_words
  );
    logic [33:0] w_lim;
    logic        w_bad_op;
    logic        w_range;
    logic        w_align;
    w_lim    = {mem_words, 2'b00};
    w_bad_op = op > OP_SB;
    w_range  = {2'b00, addr} >= w_lim;
    w_align  = ((op == OP_SW) && (addr[1:0] != 2'b00)) ||
               ((op == OP_SH) && addr[0]);
    dm_req_err = w_bad_op || w_range || w_align;
  endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin pick: on a tie the port
// not granted last time wins.
module dm_rr_pick (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: accept, one
// memory access cycle, one response cycle.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [31:0] req_pc0,
  input  logic [31:0] req_pc1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_write,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  st_e         r_state;
  logic        r_last;
  logic        r_owner;
  logic        r_err;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [2:0]  r_mem_write;
  logic [1:0]  r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [1:0]  w_grant;
  logic        w_sel;
  logic        w_acc;
  logic        w_err;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_op;
  logic [31:0] w_pc;

  dm_rr_pick u_pick (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_sel   = w_grant[1];
  assign w_acc   = (r_state == ST_IDLE) && (w_grant != 2'b00);
  assign w_addr  = w_sel ? req_addr1  : req_addr0;
  assign w_wdata = w_sel ? req_wdata1 : req_wdata0;
  assign w_op    = w_sel ? req_op1    : req_op0;
  assign w_pc    = w_sel ? req_pc1    : req_pc0;
  assign w_err   = dm_req_err(w_addr, w_op, MEM_WORDS);

  // reset gates the grant so nothing is accepted while held
  assign req_ready = (w_acc && reset) ? w_grant : 2'b00;

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_pc    = r_pc;
  assign mem_write = r_mem_write;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_op        <= OP_LW;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pc        <= '0;
      r_mem_write <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_mem_write <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_owner <= w_sel;
            r_err   <= w_err;
            r_op    <= w_op;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_pc    <= w_pc;
            if (!w_err && (w_op != OP_LW)) begin
              r_mem_write <= w_op;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rsp_rdata <= (r_op == OP_LW && !r_err) ?
                         mem_rdata : '0;
          r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
          r_rsp_err   <= r_err;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: fixed vector table, contention,
// reset corners and random traffic vs a reference model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int MW = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [2:0]  req_op0 = '0, req_op1 = '0;
  logic [31:0] req_pc0 = '0, req_pc1 = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [2:0]  mem_write;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_pc0(req_pc0), .req_pc1(req_pc1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_pc(mem_pc),
    .mem_rdata(mem_rdata)
  );

  // data memory device
  logic [31:0] dmem [0:MW-1];
  logic [31:0] w_m;
  assign w_m = (mem_write == 3'd1) ? 32'hFFFF_FFFF :
               (mem_write == 3'd2) ?
                 (mem_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
               (mem_write == 3'd3) ?
                 (32'hFF << (8 * mem_addr[1:0])) : 32'h0;
  assign mem_rdata = (mem_addr < 32'(MW * 4)) ?
                     dmem[mem_addr[13:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write != 3'd0 && mem_addr < 32'(MW * 4))
      dmem[mem_addr[13:2]] <=
        (dmem[mem_addr[13:2]] & ~w_m) | (mem_wdata & w_m);
  end

  // reference model state
  logic [31:0] rmem [0:MW-1];
  int m_last = 1;

  function automatic bit ref_err(logic [2:0] op, logic [31:0] a);
    if (op > 3) return 1'b1;
    if (a >= 32'(MW * 4)) return 1'b1;
    if (op == 3'd1 && (a % 4) != 0) return 1'b1;
    if (op == 3'd2 && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_store(logic [2:0] op, logic [31:0] a,
                           logic [31:0] wd);
    int sz;
    int off;
    int idx;
    sz  = (op == 3'd1) ? 4 : (op == 3'd2) ? 2 : 1;
    off = (op == 3'd1) ? 0 : int'(a % 4);
    idx = int'(a / 4);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + sz)
        rmem[idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } fld_t;

  task automatic drive(logic [1:0] vm, fld_t f0, fld_t f1);
    req_valid  = vm;
    req_op0    = f0.op;    req_op1    = f1.op;
    req_addr0  = f0.addr;  req_addr1  = f1.addr;
    req_wdata0 = f0.wdata; req_wdata1 = f1.wdata;
    req_pc0    = f0.pc;    req_pc1    = f1.pc;
  endtask

  // called at posedge+1 in IDLE; returns at posedge+1 in IDLE
  task automatic run_txn(logic [1:0] vm, fld_t f0, fld_t f1,
                         int ep, logic ee, logic [31:0] erd,
                         logic [2:0] ew, string nm);
    int n;
    fld_t fw;
    fw = (ep == 1) ? f1 : f0;
    drive(vm, f0, f1);
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "/ready"}, 32'(req_ready), 32'(1 << ep));
    if (req_ready == 2'b00) begin
      req_valid = '0;
      return;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk({nm, "/mem_write"}, 32'(mem_write), 32'(ew));
    chk({nm, "/mem_addr"}, mem_addr, fw.addr);
    chk({nm, "/mem_pc"}, mem_pc, fw.pc);
    if (ew != 3'd0) chk({nm, "/mem_wdata"}, mem_wdata, fw.wdata);
    chk({nm, "/rsp_early"}, 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "/rsp_valid"}, 32'(rsp_valid), 32'(1 << ep));
    chk({nm, "/rsp_err"}, 32'(rsp_err), 32'(ee));
    chk({nm, "/rsp_rdata"}, rsp_rdata, erd);
    chk({nm, "/mw_resp"}, 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk({nm, "/rsp_end"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic model_txn(logic [1:0] vm, fld_t f0, fld_t f1,
                           string nm);
    int ep;
    fld_t fw;
    logic ee;
    logic [31:0] erd;
    logic [2:0] ew;
    if (vm == 2'b11) ep = (m_last == 1) ? 0 : 1;
    else ep = vm[1] ? 1 : 0;
    fw  = (ep == 1) ? f1 : f0;
    ee  = ref_err(fw.op, fw.addr);
    erd = (!ee && fw.op == 3'd0) ? rmem[int'(fw.addr / 4)] : 32'h0;
    ew  = (!ee && fw.op != 3'd0) ? fw.op : 3'd0;
    run_txn(vm, f0, f1, ep, ee, erd, ew, nm);
    if (ew != 3'd0) ref_store(fw.op, fw.addr, fw.wdata);
    m_last = ep;
  endtask

  typedef struct {
    int          port;
    fld_t        f;
    logic        ee;
    logic [31:0] erd;
    logic [2:0]  ew;
    string       nm;
  } vec_t;

  vec_t tv[$];

  task automatic add(int p, logic [2:0] op, logic [31:0] a,
                     logic [31:0] wd, logic [31:0] pc, logic ee,
                     logic [31:0] erd, logic [2:0] ew, string nm);
    vec_t v;
    v.port = p;
    v.f = '{op: op, addr: a, wdata: wd, pc: pc};
    v.ee = ee; v.erd = erd; v.ew = ew; v.nm = nm;
    tv.push_back(v);
  endtask

  typedef struct {
    int          port;
    int          due;
    logic [31:0] rd;
  } pend_t;

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    fld_t z;
    fld_t f0;
    fld_t f1;
    pend_t q[$];
    int g;
    logic [31:0] exp_rv;

    z = '{op: 3'd0, addr: 32'h0, wdata: 32'h0, pc: 32'h0};
    for (int i = 0; i < MW; i++) begin
      dmem[i] = 32'h0;
      rmem[i] = 32'h0;
    end

    add(0, 3'd1, 32'h10, 32'hDEAD_BEEF, 32'h100, 0, 0, 3'd1, "sw10");
    add(0, 3'd0, 32'h10, 32'h0, 32'h104, 0, 32'hDEAD_BEEF, 0, "lw10");
    add(1, 3'd3, 32'h23, 32'hAB00_0000, 32'h800, 0, 0, 3'd3, "sb23");
    add(0, 3'd2, 32'h22, 32'h1234_0000, 32'h108, 0, 0, 3'd2, "sh22");
    add(1, 3'd3, 32'h21, 32'h0000_CD00, 32'h804, 0, 0, 3'd3, "sb21");
    add(1, 3'd0, 32'h23, 32'h0, 32'h808, 0, 32'h1234_CD00, 0, "lw23");
    add(0, 3'd1, 32'h12, 32'h1111_1111, 32'h10C, 1, 0, 0, "sw12");
    add(1, 3'd2, 32'h21, 32'h2222_2222, 32'h80C, 1, 0, 0, "sh21");
    add(0, 3'd0, 32'h3000, 32'h0, 32'h110, 1, 0, 0, "lw3000");
    add(1, 3'd5, 32'h0, 32'h3333_3333, 32'h810, 1, 0, 0, "op5");
    add(0, 3'd3, 32'h2FFF, 32'h7700_0000, 32'h114, 0, 0, 3'd3, "sb2fff");
    add(1, 3'd0, 32'h2FFC, 32'h0, 32'h814, 0, 32'h7700_0000, 0, "lw2ffc");
    add(0, 3'd1, 32'h2FFE, 32'h4444_4444, 32'h118, 1, 0, 0, "sw2ffe");
    add(0, 3'd2, 32'hFFFF_FFFE, 32'h5555, 32'h11C, 1, 0, 0, "shffff");

    #1 reset = 1'b0;
    #10;
    chk("rst/req_ready", 32'(req_ready), 32'd0);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/rsp_err", 32'(rsp_err), 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'd0);
    chk("rst/mem_write", 32'(mem_write), 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    chk("rst/mem_pc", mem_pc, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_last = 1;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      f0 = (tv[i].port == 0) ? tv[i].f : z;
      f1 = (tv[i].port == 1) ? tv[i].f : z;
      run_txn(2'(1 << tv[i].port), f0, f1, tv[i].port,
              tv[i].ee, tv[i].erd, tv[i].ew, tv[i].nm);
      if (tv[i].ew != 3'd0)
        ref_store(tv[i].f.op, tv[i].f.addr, tv[i].f.wdata);
      m_last = tv[i].port;
    end

    // contention straight after reset: 0,1,0,1,0,1
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_last = 1;
    f0 = '{op: 3'd0, addr: 32'h10, wdata: 32'h0, pc: 32'h200};
    f1 = '{op: 3'd0, addr: 32'h20, wdata: 32'h0, pc: 32'h900};
    drive(2'b11, f0, f1);
    g = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (g == 6) req_valid = '0;
      #1;
      total++;
      if (req_ready == 2'b11) begin
        bad++;
        $display("FAIL cont/both got=%b want=one-hot", req_ready);
      end
      exp_rv = (q.size() > 0 && q[0].due == c) ?
               32'(1 << q[0].port) : 32'd0;
      chk("cont/rsp_valid", 32'(rsp_valid), exp_rv);
      if (exp_rv != 0) begin
        chk("cont/rsp_rdata", rsp_rdata, q[0].rd);
        void'(q.pop_front());
      end
      if (req_ready != 2'b00) begin
        chk("cont/grant", 32'(req_ready), 32'(1 << (g % 2)));
        q.push_back('{port: g % 2, due: c + 2,
                      rd: rmem[(g % 2 == 0) ? 4 : 8]});
        g++;
      end
      if (g == 6 && q.size() == 0) break;
    end
    chk("cont/grants", 32'(g), 32'd6);
    chk("cont/left", 32'(q.size()), 32'd0);
    req_valid = '0;
    m_last = 1;
    @(posedge clk); #1;

    // reset 1 ns into ACCESS of sw 0x40
    f0 = '{op: 3'd1, addr: 32'h40, wdata: 32'h55AA_55AA, pc: 32'h300};
    drive(2'b01, f0, z);
    #1;
    chk("rma/ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rma/mw_pre", 32'(mem_write), 32'd1);
    reset = 1'b0;
    #1;
    chk("rma/mem_write", 32'(mem_write), 32'd0);
    chk("rma/mem_addr", mem_addr, 32'd0);
    chk("rma/mem_wdata", mem_wdata, 32'd0);
    chk("rma/mem_pc", mem_pc, 32'd0);
    chk("rma/req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rma/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rma/mem40", dmem[16], rmem[16]);
    @(posedge clk); #1;
    chk("rma/rsp_valid2", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    #2 reset = 1'b1;
    m_last = 1;
    @(posedge clk); #1;

    // post-reset priority via the model
    f0 = '{op: 3'd0, addr: 32'h40, wdata: 32'h0, pc: 32'h400};
    f1 = '{op: 3'd0, addr: 32'h10, wdata: 32'h0, pc: 32'hA00};
    model_txn(2'b11, f0, f1, "postrst");

    for (int i = 0; i < 80; i++) begin
      fld_t fr[2];
      int r;
      for (int p = 0; p < 2; p++) begin
        r = int'($urandom_range(0, 9));
        fr[p].op = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
        if ($urandom_range(0, 7) == 0)
          fr[p].addr = 32'h2FF8 + $urandom_range(0, 15);
        else
          fr[p].addr = $urandom_range(0, 47);
        fr[p].wdata = $urandom;
        fr[p].pc = $urandom;
      end
      model_txn(2'($urandom_range(1, 3)), fr[0], fr[1], "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. Port 0 serves the CPU memory stage; port 1 serves a debug/DMA requester. The block accepts one request at a time using round-robin arbitration, checks its alignment and range, and drives the memory's address, store-data and write-mode lines for exactly one cycle. It then returns a registered response to the owner.

## Interface
- `MEM_WORDS`, 3072: memory depth in words; legal byte addresses are 0 to `MEM_WORDS*4-1`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; low forces the reset state immediately.
- `req_valid[1:0]` in 2: request valid, one bit per port.
- `req_ready[1:0]` out 2: request accepted this cycle (one-hot or zero).
- `req_addr0`, `req_addr1` in 32: byte address.
- `req_wdata0`, `req_wdata1` in 32: store data, already lane-placed by the requester.
- `req_op0`, `req_op1` in 3: 0 = load word, 1 = sw, 2 = sh, 3 = sb; codes 4–7 are illegal.
- `req_pc0`, `req_pc1` in 32: PC forwarded to the memory for the write trace.
- `rsp_valid[1:0]` out 2: one-cycle response pulse to the owning port.
- `rsp_rdata` out 32: word read (loads only); 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`; set for misaligned, out-of-range or illegal-op requests.
- `mem_addr` out 32: to memory `Addr`.
- `mem_wdata` out 32: to memory `StoreData`.
- `mem_write` out 3: to memory `MemWrite` (0 none, 1 word, 2 half, 3 byte).
- `mem_pc` out 32: to memory `PC`.
- `mem_rdata` in 32: from memory `MemoryData` (combinational read).

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE**
  - If any `req_valid` is set, pick the winner and assert its `req_ready` combinationally.
  - Arbitration is round-robin. The port not granted last time wins a tie; after reset, port 0 has priority.
  - On the accept edge: latch addr, wdata, op, pc and the owner into registers; compute the error flag; go to ACCESS.
- **Error conditions**
  - op > 3.
  - addr ≥ `MEM_WORDS*4`.
  - op 1 with `addr[1:0]` ≠ 0.
  - op 2 with `addr[0]` ≠ 0.
- **ACCESS (exactly one cycle)**
  - `mem_addr`, `mem_wdata` and `mem_pc` come from the latched values.
  - `mem_write` = latched op for legal stores; 0 for loads and errored requests.
  - The memory commits the store at the end of this cycle.
  - For loads, `mem_rdata` is captured into `rsp_rdata` on the same edge. Go to RESP.
- **RESP (exactly one cycle)**
  - `rsp_valid[owner]` = 1, `rsp_err` = latched flag.
  - Update the round-robin pointer to the owner. Go to IDLE.
  - Responses have no backpressure; requesters must always accept them.
- **Outside ACCESS:** `mem_write` is 0; `mem_addr`, `mem_wdata` and `mem_pc` hold their last values.
- **`req_ready`** is 0 in ACCESS and RESP. A requester that keeps `req_valid` high is served in a later IDLE.
- **Sub-word loads** return the full aligned word; lane extraction belongs to the requester.

## Timing
- **Reset values:** state IDLE; `req_ready`, `rsp_valid`, `rsp_err`, `mem_write`, `rsp_rdata`, `mem_addr`, `mem_wdata` and `mem_pc` all 0; round-robin pointer favours port 0.
- **Latency:** accept edge (IDLE) → store commit or read capture (end of ACCESS) → `rsp_valid` during RESP. The response is high 2 cycles after the `req_ready` cycle.
- **Throughput:** one request per 3 cycles under continuous demand; both ports busy alternate 0, 1, 0, 1.
- **Simultaneous valid on both ports:** exactly one `req_ready` is asserted, never both.
- **Reset asserted mid-ACCESS:** `mem_write` drops to 0 asynchronously and no store occurs at the next edge. The pending request is discarded with no response.
- **Reset asserted mid-RESP:** the response pulse is truncated to zero width.
- **Reset deassertion:** takes effect on the next rising `clk` edge.

## Structure
- **Package `dm_arb_pkg`:**
  - op code constants (`OP_LW`, `OP_SW`, `OP_SH`, `OP_SB`);
  - state enum (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`);
  - helper function `dm_req_err(addr, op, mem_words)`.
- **Sub-module `dm_rr_pick`:** combinational two-way round-robin pick from `req_valid` and the last-grant bit; outputs the one-hot grant. All state lives in `dm_arbiter`.

## Test plan
- **Word round-trip, port 0:** sw addr 0x10 data 0xDEADBEEF, then lw 0x10.
  - `mem_write` = 1 for one cycle with `mem_addr` 0x10.
  - Load response `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, two cycles after accept.
- **Contention:** both ports hold valid for 6 requests.
  - Grants go 0, 1, 0, 1, 0, 1; `req_ready` is never 2'b11.
  - Each `rsp_valid` pulse reaches the correct port.
- **Sub-word stores:** sb addr 0x23 data 0xAB000000 (port 1) and sh addr 0x22 data 0x1234_0000.
  - `mem_write` = 3 then 2 on the respective ACCESS cycles.
  - `mem_pc` equals the requester PC.
- **Errors:** sw 0x12, sh 0x21, lw 0x3000, op 5.
  - Each gives `rsp_err` = 1 and `rsp_rdata` = 0.
  - `mem_write` stays 0 throughout.
- **Reset mid-ACCESS:** pull `reset` low 1 ns into ACCESS of sw 0x40.
  - `mem_write` is 0 immediately; no response pulse.
  - Outputs are at reset values; memory word 0x40 is unchanged.
- **Post-reset priority:** both ports valid on the first IDLE after reset; port 0 is granted first.
